spongent_pad_feeder: RTL and testbench

Upstream stage of the SPONGENT sponge core inside the HMAC datapath. It captures a fixed-width message word, applies SPONGENT padding (a single 1 bit, then zeros up to a multiple of the rate), and delivers the result as rate-sized blocks over a valid/ready handshake to the absorb phase of the sponge. The core pulls blocks at its own pace. The feeder signals the last block so the core can switch to permutation and squeeze.

---
 rtl/spongent_pad_feeder_pkg.sv | 20 ++
 rtl/spongent_pad_feeder_if.sv | 23 ++
 rtl/spongent_pad_feeder.sv | 94 +++++++++
 tb/tb_spongent_pad_feeder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/spongent_pad_feeder_pkg.sv
// Shared SPONGENT constants, feeder state type and block-count helper.
package spongent_pkg;

    // SPONGENT-88/80/8 geometry: rate r, capacity c, state width N = r + c.
    localparam int unsigned SPONGENT_R = 8;
    localparam int unsigned SPONGENT_C = 80;
    localparam int unsigned SPONGENT_N = SPONGENT_R + SPONGENT_C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of rate blocks after padding; padding always adds at least one bit.
    function automatic int unsigned nb_blocks(input int unsigned msg_w, input int unsigned r_w);
        return msg_w / r_w + 1;
    endfunction

endpackage

// File: rtl/spongent_pad_feeder_if.sv
// Block stream from the pad feeder to the sponge absorb phase.
interface spongent_pad_feeder_if #(
    parameter int unsigned R_WIDTH = 8
);
    logic [R_WIDTH-1:0] block_o;
    logic               block_valid_o;
    logic               block_ready_i;
    logic               last_o;

    modport master (
        output block_o,
        output block_valid_o,
        output last_o,
        input  block_ready_i
    );

    modport slave (
        input  block_o,
        input  block_valid_o,
        input  last_o,
        output block_ready_i
    );
endinterface

// File: rtl/spongent_pad_feeder.sv
// Captures a message, applies SPONGENT 10* padding and streams rate-sized blocks.
// Optional abort input enabled by defining SPONGENT_FEEDER_ABORT_EN.
module spongent_pad_feeder
    import spongent_pkg::*;
#(
    parameter int unsigned MSG_WIDTH = 64,
    parameter int unsigned R_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [MSG_WIDTH-1:0]    msg_i,
`ifdef SPONGENT_FEEDER_ABORT_EN
    input  logic                    abort_i,
`endif
    spongent_pad_feeder_if.master   blk,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int unsigned NB    = nb_blocks(MSG_WIDTH, R_WIDTH);
    localparam int unsigned PAD_W = NB * R_WIDTH;
    localparam int unsigned ZW    = PAD_W - MSG_WIDTH - 1;
    localparam int unsigned CNT_W = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB - 1);

    state_e             state_q, state_d;
    logic [PAD_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAD_W-1:0]   pad_load;

    // {msg, 1, zeros} left-aligned in the shift register.
    assign pad_load = PAD_W'({msg_i, 1'b1}) << ZW;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SEND;
                    sr_d    = pad_load;
                    cnt_d   = '0;
                end
            end
            SEND: begin
                if (blk.block_ready_i) begin
                    sr_d  = sr_q << R_WIDTH;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SPONGENT_FEEDER_ABORT_EN
        // Abort overrides any handshake in the same cycle.
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            sr_d    = '0;
            cnt_d   = '0;
        end
`endif
    end

    // Outputs decoded from registered state only; no path from block_ready_i.
    assign blk.block_o       = sr_q[PAD_W-1 -: R_WIDTH];
    assign blk.block_valid_o = (state_q == SEND);
    assign blk.last_o        = (state_q == SEND) && (cnt_q == LAST_CNT);
    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == DONE);

endmodule

// File: tb/tb_spongent_pad_feeder.sv
// Directed self-checking bench for spongent_pad_feeder (64/8 and 60/8 builds).
module tb_spongent_pad_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start64, start60;
    logic [63:0] msg64;
    logic [59:0] msg60;
    logic        busy64, done64, busy60, done60;
`ifdef SPONGENT_FEEDER_ABORT_EN
    logic        abort64, abort60;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] exp64 [9];
    logic [7:0] exp60 [8];

    spongent_pad_feeder_if #(.R_WIDTH(8)) bus64 ();
    spongent_pad_feeder_if #(.R_WIDTH(8)) bus60 ();

    spongent_pad_feeder #(.MSG_WIDTH(64), .R_WIDTH(8)) dut64 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start64),
        .msg_i   (msg64),
`ifdef SPONGENT_FEEDER_ABORT_EN
        .abort_i (abort64),
`endif
        .blk     (bus64),
        .busy_o  (busy64),
        .done_o  (done64)
    );

    spongent_pad_feeder #(.MSG_WIDTH(60), .R_WIDTH(8)) dut60 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start60),
        .msg_i   (msg60),
`ifdef SPONGENT_FEEDER_ABORT_EN
        .abort_i (abort60),
`endif
        .blk     (bus60),
        .busy_o  (busy60),
        .done_o  (done60)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic start_stream64(input logic [63:0] m);
        start64 = 1'b1;
        msg64   = m;
        tick();
        start64 = 1'b0;
    endtask

    initial begin
        int k;
        int idx;
        exp64 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h80};
        exp60 = '{8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h18};
        rst = 1'b0;
        start64 = 1'b0; start60 = 1'b0;
        msg64 = '0; msg60 = '0;
        bus64.block_ready_i = 1'b0;
        bus60.block_ready_i = 1'b0;
`ifdef SPONGENT_FEEDER_ABORT_EN
        abort64 = 1'b0; abort60 = 1'b0;
`endif
        #2;
        chk("rst_block", 64'(bus64.block_o), 64'h0);
        chk("rst_valid", 64'(bus64.block_valid_o), 64'h0);
        chk("rst_last", 64'(bus64.last_o), 64'h0);
        chk("rst_busy", 64'(busy64), 64'h0);
        chk("rst_done", 64'(done64), 64'h0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Ready while idle does nothing.
        bus64.block_ready_i = 1'b1;
        tick(); tick();
        chk("idle_ready_busy", 64'(busy64), 64'h0);
        chk("idle_ready_valid", 64'(bus64.block_valid_o), 64'h0);

        // Full-rate stream, 64-bit message.
        start_stream64(64'h0123456789ABCDEF);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("s1_block%0d", i), 64'(bus64.block_o), 64'(exp64[i]));
            chk($sformatf("s1_last%0d", i), 64'(bus64.last_o), (i == 8) ? 64'h1 : 64'h0);
            chk($sformatf("s1_valid%0d", i), 64'(bus64.block_valid_o), 64'h1);
            tick();
        end
        chk("s1_done_c10", 64'(done64), 64'h1);
        chk("s1_busy_c10", 64'(busy64), 64'h1);
        chk("s1_valid_c10", 64'(bus64.block_valid_o), 64'h0);
        tick();
        chk("s1_done_c11", 64'(done64), 64'h0);
        chk("s1_busy_c11", 64'(busy64), 64'h0);

        // Earliest restart, with a stray start in cycle 3 that must be ignored.
        start_stream64(64'h0123456789ABCDEF);
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                start64 = 1'b1;
                msg64   = 64'hFFFF_0000_AAAA_5555;
            end else begin
                start64 = 1'b0;
            end
            chk($sformatf("ign_block%0d", i), 64'(bus64.block_o), 64'(exp64[i]));
            tick();
        end
        start64 = 1'b0;
        chk("ign_done", 64'(done64), 64'h1);
        tick();
        chk("ign_idle", 64'(busy64), 64'h0);

        // Backpressure: ready high one cycle in three.
        bus64.block_ready_i = 1'b0;
        start_stream64(64'h0123456789ABCDEF);
        idx = 0;
        k = 0;
        while (idx < 9 && k < 60) begin
            bus64.block_ready_i = (k % 3 == 0);
            chk($sformatf("bp_block_k%0d", k), 64'(bus64.block_o), 64'(exp64[idx]));
            chk($sformatf("bp_last_k%0d", k), 64'(bus64.last_o), (idx == 8) ? 64'h1 : 64'h0);
            chk($sformatf("bp_valid_k%0d", k), 64'(bus64.block_valid_o), 64'h1);
            if (bus64.block_ready_i) idx++;
            tick();
            k++;
        end
        chk("bp_count", 64'(idx), 64'd9);
        chk("bp_done", 64'(done64), 64'h1);
        bus64.block_ready_i = 1'b1;
        tick();

        // Reset during block 5 clears outputs at once; restart begins at block 0.
        start_stream64(64'h0123456789ABCDEF);
        for (int i = 0; i < 4; i++) tick();
        chk("mid_block5", 64'(bus64.block_o), 64'h89);
        rst = 1'b0;
        #1;
        chk("mid_rst_block", 64'(bus64.block_o), 64'h0);
        chk("mid_rst_valid", 64'(bus64.block_valid_o), 64'h0);
        chk("mid_rst_last", 64'(bus64.last_o), 64'h0);
        chk("mid_rst_busy", 64'(busy64), 64'h0);
        chk("mid_rst_done", 64'(done64), 64'h0);
        tick();
        rst = 1'b1;
        tick();
        start_stream64(64'h0123456789ABCDEF);
        chk("post_rst_b0", 64'(bus64.block_o), 64'h01);
        tick();
        chk("post_rst_b1", 64'(bus64.block_o), 64'h23);
        for (int i = 0; i < 10; i++) tick();
        chk("post_rst_idle", 64'(busy64), 64'h0);

        // 60-bit message: padding lands inside the last byte.
        bus60.block_ready_i = 1'b1;
        start60 = 1'b1;
        msg60   = 60'hFEDCBA987654321;
        tick();
        start60 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m60_block%0d", i), 64'(bus60.block_o), 64'(exp60[i]));
            chk($sformatf("m60_last%0d", i), 64'(bus60.last_o), (i == 7) ? 64'h1 : 64'h0);
            tick();
        end
        chk("m60_done", 64'(done60), 64'h1);
        tick();
        chk("m60_idle", 64'(busy60), 64'h0);

`ifdef SPONGENT_FEEDER_ABORT_EN
        // Abort together with the handshake of block 4.
        start_stream64(64'h0123456789ABCDEF);
        tick(); tick(); tick();
        chk("ab_block4", 64'(bus64.block_o), 64'h67);
        abort64 = 1'b1;
        tick();
        abort64 = 1'b0;
        chk("ab_busy", 64'(busy64), 64'h0);
        chk("ab_valid", 64'(bus64.block_valid_o), 64'h0);
        chk("ab_done", 64'(done64), 64'h0);
        chk("ab_block", 64'(bus64.block_o), 64'h0);
        tick();
        chk("ab_done_next", 64'(done64), 64'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
